// File: rtl/ledbar_pkg.sv
// Shared types for the LED level-bar driver: bar state encoding, display
// mode encoding and the level-to-state mapping used by the top.
package ledbar_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BAR   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_BAR = 1'b0,
    MODE_DOT = 1'b1
  } mode_e;

  // A level is EMPTY at zero, FULL at (or beyond) the LED count, BAR in between.
  function automatic state_e level_state(input int lvl, input int n_led);
    state_e s;
    if (lvl == 0)
      s = EMPTY;
    else if (lvl >= n_led)
      s = FULL;
    else
      s = BAR;
    return s;
  endfunction

endpackage

// File: rtl/led_level_bar_if.sv
// Level/mode request bus into the LED bar driver and the bar outputs back.
// master = level-producing logic, slave = the bar driver.
interface led_level_bar_if #(
  parameter int N_LED = 13
);
  localparam int LW = $clog2(N_LED + 1);

  logic [LW-1:0]    LEVEL;
  logic             LEVEL_VLD;
  logic             MODE;
  logic [N_LED-1:0] LED;
  logic             FULL;

  modport master (
    output LEVEL,
    output LEVEL_VLD,
    output MODE,
    input  LED,
    input  FULL
  );

  modport slave (
    input  LEVEL,
    input  LEVEL_VLD,
    input  MODE,
    output LED,
    output FULL
  );

endinterface

// File: rtl/blink_tick.sv
// Blink timebase: counts HALF_PERIOD cycles per phase and toggles the phase
// on every wrap. restart (counter 0, phase 1) wins over run; when neither is
// asserted the unit sits idle with counter and phase at 0.
module blink_tick #(
  parameter int HALF_PERIOD = 50_000_000
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic run,
  input  logic restart,
  output logic phase
);

  localparam int CW = $clog2(HALF_PERIOD);

  logic [CW-1:0] cnt_q;
  logic          tick;

  assign tick = (cnt_q == CW'(HALF_PERIOD - 1));

  // Counter and phase: restart first, then free-run with wrap, else idle at 0.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
      phase <= 1'b0;
    end else if (restart) begin
      cnt_q <= '0;
      phase <= 1'b1;
    end else if (run) begin
      if (tick) begin
        cnt_q <= '0;
        phase <= ~phase;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else begin
      cnt_q <= '0;
      phase <= 1'b0;
    end
  end

endmodule

// File: rtl/led_level_bar.sv
// LED level-bar driver: latches a saturated fill level, tracks EMPTY/BAR/FULL,
// and drives an N_LED bar as a thermometer or a single dot. The top LED blinks
// while FULL, with the blink restarting on each entry to FULL.
// Optional: define LEDBAR_EMPTY_BLINK_EN to blink LED[0] while EMPTY.
module led_level_bar
  import ledbar_pkg::*;
#(
  parameter int N_LED       = 13,
  parameter int HALF_PERIOD = 50_000_000
) (
  input  logic CLOCK,
  input  logic RESET_N,
  led_level_bar_if.slave bus
);

  localparam int LW = $clog2(N_LED + 1);

  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_sat;
  logic [LW-1:0]    level_d;
  state_e           state_q;
  state_e           state_d;
  logic             full_q;
  logic             blink_run;
  logic             blink_restart;
  logic             phase;
  logic [N_LED-1:0] led_d;
  logic [N_LED-1:0] led_q;

  // Next level/state and blink control; state follows the value being latched.
  always_comb begin
    level_sat     = (bus.LEVEL > LW'(N_LED)) ? LW'(N_LED) : bus.LEVEL;
    level_d       = level_q;
    blink_run     = 1'b0;
    blink_restart = 1'b0;
    if (bus.LEVEL_VLD)
      level_d = level_sat;
    state_d = level_state(int'(level_d), N_LED);
    if (state_d == FULL) begin
      if (state_q != FULL)
        blink_restart = 1'b1;
      else
        blink_run = 1'b1;
    end
`ifdef LEDBAR_EMPTY_BLINK_EN
    if (state_d == EMPTY) begin
      if (state_q != EMPTY)
        blink_restart = 1'b1;
      else
        blink_run = 1'b1;
    end
`endif
  end

  // Level latch, state register and registered FULL flag.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      level_q <= '0;
      state_q <= EMPTY;
      full_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      state_q <= state_d;
      full_q  <= (state_d == FULL);
    end
  end

  blink_tick #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_blink (
    .CLOCK  (CLOCK),
    .RESET_N(RESET_N),
    .run    (blink_run),
    .restart(blink_restart),
    .phase  (phase)
  );

  // Bar pattern from the latched level, current mode and blink phase.
  always_comb begin
    led_d = '0;
    case (state_q)
      BAR: begin
        for (int i = 0; i < N_LED; i++) begin
          if (bus.MODE == MODE_DOT)
            led_d[i] = (i == int'(level_q) - 1);
          else
            led_d[i] = (i < int'(level_q));
        end
      end
      FULL: begin
        led_d            = (bus.MODE == MODE_DOT) ? '0 : '1;
        led_d[N_LED-1]   = phase;
      end
      EMPTY: begin
`ifdef LEDBAR_EMPTY_BLINK_EN
        led_d[0] = phase;
`else
        led_d = '0;
`endif
      end
      default: led_d = '0;
    endcase
  end

  // LED output register.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)
      led_q <= '0;
    else
      led_q <= led_d;
  end

  assign bus.LED  = led_q;
  assign bus.FULL = full_q;

endmodule

// File: tb/tb_led_level_bar.sv
// Scoreboard bench for led_level_bar (N_LED=13, HALF_PERIOD=4). Stimulus pushes
// cycle-tagged expected LED/FULL values; the monitor checks them each negedge.
module tb_led_level_bar;

  localparam int N_LED = 13;
  localparam int HP    = 4;

  typedef struct {
    int               cyc;
    logic [N_LED-1:0] led;
    logic             full;
    string            name;
  } expItem_t;

  expItem_t expQ[$];

  logic CLOCK   = 1'b0;
  logic RESET_N = 1'b0;
  int   cyc     = 0;
  int   testsRun    = 0;
  int   testsFailed = 0;

  led_level_bar_if #(.N_LED(N_LED)) bus ();

  led_level_bar #(
    .N_LED      (N_LED),
    .HALF_PERIOD(HP)
  ) dut (
    .CLOCK  (CLOCK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  always #5 CLOCK = ~CLOCK;

  // Edge counter used to tag when each expectation becomes due.
  always @(posedge CLOCK) cyc <= cyc + 1;

  // Insert keeping the queue ordered by due cycle.
  function automatic void pushExp(input int c, input logic [N_LED-1:0] led,
                                  input logic full, input string name);
    expItem_t it;
    int idx;
    it.cyc  = c;
    it.led  = led;
    it.full = full;
    it.name = name;
    idx = expQ.size();
    while (idx > 0 && expQ[idx-1].cyc > c)
      idx--;
    expQ.insert(idx, it);
  endfunction

  // Expected blink pattern: after entry at edge base, value k cycles later is
  // onVal during the first HP cycles of each period, offVal in the second.
  function automatic void pushBlink(input int base, input int k0, input int k1,
                                    input logic [N_LED-1:0] onVal,
                                    input logic [N_LED-1:0] offVal,
                                    input logic full, input string tag);
    for (int k = k0; k <= k1; k++)
      pushExp(base + k, ((((k - 1) / HP) % 2) == 0) ? onVal : offVal, full,
              $sformatf("%s_k%0d", tag, k));
  endfunction

  task automatic checkOutput(input string name,
                             input logic [N_LED-1:0] actLed, input logic actFull,
                             input logic [N_LED-1:0] expLed, input logic expFull);
    testsRun++;
    if (actLed !== expLed || actFull !== expFull) begin
      testsFailed++;
      $display("[TB] FAIL %s: got LED=%04h FULL=%b, expected LED=%04h FULL=%b",
               name, actLed, actFull, expLed, expFull);
    end
  endtask

  // Monitor: compare every expectation that has come due at this negedge.
  always @(negedge CLOCK) begin : monitor
    expItem_t it;
    while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
      it = expQ.pop_front();
      checkOutput(it.name, bus.LED, bus.FULL, it.led, it.full);
    end
  end

  task automatic tick();
    @(negedge CLOCK);
    bus.LEVEL_VLD = 1'b0;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c)
      tick();
  endtask

  // Present a strobe now (just after a negedge); returns the sampling edge.
  task automatic applyStimulus(input int lvl, input logic mode, output int edgeCyc);
    bus.LEVEL     = 4'(lvl);
    bus.LEVEL_VLD = 1'b1;
    bus.MODE      = mode;
    edgeCyc       = cyc + 1;
  endtask

  initial begin
    int c0, e1, e2, eTmp, e4, e5, p, e6, e7, guard;
    bus.LEVEL     = '0;
    bus.LEVEL_VLD = 1'b0;
    bus.MODE      = 1'b0;

    // Reset and release at a negedge.
    repeat (3) tick();
    RESET_N = 1'b1;
    c0 = cyc;
    pushExp(c0 + 1, 13'h0000, 1'b0, "reset_c1");
    pushExp(c0 + 2, 13'h0000, 1'b0, "reset_c2");
    waitUntil(c0 + 3);

    // Thermometer level 5: LED appears one edge after FULL/state.
    applyStimulus(5, 1'b0, e1);
    pushExp(e1,     13'h0000, 1'b0, "bar5_latency");
    pushExp(e1 + 1, 13'h001F, 1'b0, "bar5_led");
    pushExp(e1 + 2, 13'h001F, 1'b0, "bar5_hold");
    waitUntil(e1 + 2);

    // Full level: top LED blinks 4 on / 4 off from entry.
    applyStimulus(13, 1'b0, e2);
    pushExp(e2, 13'h001F, 1'b1, "full_entry");
    pushBlink(e2, 1, 32, 13'h1FFF, 13'h0FFF, 1'b1, "full_blink");
    waitUntil(e2 + 11);
    // Re-strobe full on a tick edge, then an out-of-range level: no restart.
    applyStimulus(13, 1'b0, eTmp);
    waitUntil(e2 + 17);
    applyStimulus(15, 1'b0, eTmp);
    waitUntil(e2 + 32);

    // Dot mode, level 3.
    applyStimulus(3, 1'b1, e4);
    pushExp(e4,     13'h1000, 1'b0, "dot3_leave_full");
    pushExp(e4 + 1, 13'h0004, 1'b0, "dot3_led");
    pushExp(e4 + 2, 13'h0004, 1'b0, "dot3_hold");
    waitUntil(e4 + 2);

    // Dot mode full, then switch to thermometer mid-blink without a strobe.
    applyStimulus(13, 1'b1, e5);
    pushExp(e5, 13'h0004, 1'b1, "dotfull_entry");
    pushBlink(e5, 1, 8, 13'h1000, 13'h0000, 1'b1, "dotfull_blink");
    pushBlink(e5, 9, 16, 13'h1FFF, 13'h0FFF, 1'b1, "modeswitch_blink");
    waitUntil(e5 + 8);
    bus.MODE = 1'b0;
    waitUntil(e5 + 17);

    // Asynchronous reset mid-FULL, held about one cycle.
    p = cyc + 1;
    pushExp(p, 13'h0000, 1'b0, "async_reset");
    for (int i = 1; i <= 4; i++)
      pushExp(p + i, 13'h0000, 1'b0, $sformatf("post_reset_%0d", i));
    @(posedge CLOCK);
    #2 RESET_N = 1'b0;
    @(posedge CLOCK);
    #2 RESET_N = 1'b1;
    tick();
    waitUntil(p + 5);

    // BAR back to EMPTY.
    applyStimulus(5, 1'b0, e6);
    waitUntil(e6 + 2);
    applyStimulus(0, 1'b0, e7);
    pushExp(e7, 13'h001F, 1'b0, "empty_entry");
`ifdef LEDBAR_EMPTY_BLINK_EN
    pushBlink(e7, 1, 12, 13'h0001, 13'h0000, 1'b0, "empty_blink");
`else
    pushBlink(e7, 1, 12, 13'h0000, 13'h0000, 1'b0, "empty_dark");
`endif
    waitUntil(e7 + 12);

    // Drain with a bound; anything left over is a miss.
    guard = 0;
    while (expQ.size() > 0 && guard < 20) begin
      tick();
      guard++;
    end
    while (expQ.size() > 0) begin
      expItem_t it;
      it = expQ.pop_front();
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: never checked, expected LED=%04h FULL=%b",
               it.name, it.led, it.full);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/led_level_bar.md
# led_level_bar

Parametrised LED level-bar driver: latches a fill level, shows it on an N-LED bar as a thermometer or a single dot, and blinks the top LED at a programmable rate once the bar is full. It sits between the level-producing logic (counter/reservoir model) and the board LED pins, replacing the fixed 13-LED full-only blinker. Blink timing restarts cleanly on every entry to FULL, and out-of-range levels saturate.

## Interface
- N_LED, 13, number of bar LEDs (≥2)
- HALF_PERIOD, 50_000_000, CLOCK cycles per blink phase (≥2); 1 Hz blink at 100 MHz
- LW, $clog2(N_LED+1), level width (derived, not overridden)
- CLOCK  in  1  system clock, all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- LEVEL  in  LW  requested fill level, 0..N_LED (larger values saturate)
- LEVEL_VLD  in  1  one-cycle strobe; LEVEL sampled when high
- MODE  in  1  0 = thermometer bar, 1 = single dot; sampled every cycle
- LED  out  N_LED  bar outputs, registered
- FULL  out  1  high while state is FULL, registered

## Operation
- level_q: latched from LEVEL on LEVEL_VLD, saturated to N_LED; holds otherwise. Reset 0.
- States: EMPTY (level_q = 0), BAR (0 < level_q < N_LED), FULL (level_q = N_LED). State is a pure function of the value being written into level_q, updated on the same edge. Reset state EMPTY.
- Blink unit: counter 0..HALF_PERIOD-1, width $clog2(HALF_PERIOD); tick when counter = HALF_PERIOD-1, counter wraps to 0; phase toggles on tick.
- Entry to FULL (from EMPTY or BAR): counter cleared, phase forced 1. Re-strobe of a full level while in FULL is not an entry: counter/phase run on undisturbed.
- Outside FULL (and EMPTY blink disabled): counter and phase held at 0.
- LED, MODE=0: BAR → LED[i] = (i < level_q); FULL → LED[N_LED-2:0] all 1, LED[N_LED-1] = phase; EMPTY → all 0.
- LED, MODE=1: BAR → only LED[level_q-1] = 1; FULL → only LED[N_LED-1] = phase; EMPTY → all 0.
- MODE change takes effect on next LED update; does not disturb state or blink.

## Timing
- Reset values: LED = 0, FULL = 0, level_q = 0, counter = 0, phase = 0, state EMPTY; reset asynchronous assert, synchronous release.
- LEVEL_VLD sampled at edge E: level_q/state/FULL valid after E; LED reflects new level after E+1 (2-cycle latency strobe→LED).
- After FULL entry at edge E: top LED on from E+1 for HALF_PERIOD cycles, then off HALF_PERIOD, repeating (period 2·HALF_PERIOD).
- Leaving FULL mid-phase: top LED follows bar rules at next LED update; no residual blink.
- LEVEL_VLD on a tick cycle in FULL with full level: toggle happens normally.
- RESET_N low mid-blink: LED and FULL drop to 0 immediately.

## Configuration
- LEDBAR_EMPTY_BLINK_EN defined: in EMPTY, LED[0] = phase (both modes); blink unit runs in EMPTY with the same clear-on-entry rule (counter 0, phase 1 on entering EMPTY, including out of reset release—first tick after HALF_PERIOD cycles, phase starts 0 after reset then toggles).
- Not defined: EMPTY drives all LEDs 0, blink unit idle outside FULL.

## Structure
- Package ledbar_pkg: state enum (EMPTY, BAR, FULL), MODE encodings (MODE_BAR = 0, MODE_DOT = 1).
- Sub-module blink_tick: parameter HALF_PERIOD; inputs CLOCK, RESET_N, run, restart; output phase. Owns counter and phase; restart has priority over run.
- Top: level latch, state register, LED decode register.

## Test plan
- N_LED=13, HALF_PERIOD=4: reset, strobe LEVEL=5 MODE=0 → two cycles later LED = 0x001F, FULL = 0.
- Strobe LEVEL=13 → FULL=1 next edge; LED = 0x1FFF for 4 cycles, 0x0FFF for 4, repeating.
- In FULL, re-strobe LEVEL=13 on a tick cycle → toggle pattern unbroken; then strobe LEVEL=15 → saturates, FULL stays 1, no restart.
- MODE=1 with LEVEL=3 → LED = 0x0004; LEVEL=13 → LED alternates 0x1000 / 0x0000 every 4 cycles.
- Drop RESET_N mid-FULL for 1 cycle → LED = 0, FULL = 0 asynchronously; after release LED stays 0 until next strobe.
- With LEDBAR_EMPTY_BLINK_EN: strobe LEVEL=0 from BAR → LED[0] high 4 cycles, low 4, other LEDs 0; without macro LED = 0.
